// File: rtl/sum_accumulator_pkg.sv
// rtl/sum_accumulator_pkg.sv - shared state encoding and adder result width
package sum_accumulator_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_ACCUM = 2'd1;
  localparam state_t S_DONE  = 2'd2;

  // {Carry_reg, Sum_reg} from the upstream 2-bit adder
  localparam int RESULT_W = 3;

endpackage

// File: rtl/sum_accumulator_if.sv
// rtl/sum_accumulator_if.sv - sample input and frame total handshake bundle
interface sum_accumulator_if #(
  parameter int ACC_W = 8
);
  import sum_accumulator_pkg::*;

  logic                  Start;
  logic                  In_valid;
  logic                  In_ready;
  logic                  Carry_in;
  logic [RESULT_W-2:0]   Sum_in;
  logic                  Out_valid;
  logic                  Out_ready;
  logic [ACC_W-1:0]      Acc_sum;
  logic                  Overflow;
  logic                  Busy;

  modport master (
    output Start, In_valid, Carry_in, Sum_in, Out_ready,
    input  In_ready, Out_valid, Acc_sum, Overflow, Busy
  );

  modport slave (
    input  Start, In_valid, Carry_in, Sum_in, Out_ready,
    output In_ready, Out_valid, Acc_sum, Overflow, Busy
  );

endinterface

// File: rtl/sum_accumulator.sv
// rtl/sum_accumulator.sv - frames NUM_SAMPLES adder results into a saturating total
module sum_accumulator
  import sum_accumulator_pkg::*;
#(
  parameter int NUM_SAMPLES = 4,
  parameter int ACC_W       = 8
) (
  input logic              Clk,
  input logic              Reset,
  sum_accumulator_if.slave bus
);

  localparam int               CNT_W    = $clog2(NUM_SAMPLES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SAMPLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             accept;
  logic             frame_start;
  logic [ACC_W:0]   sum_wide;

  assign accept      = (state == S_ACCUM) && bus.In_valid;
  assign frame_start = bus.Start &&
                       ((state == S_IDLE) || ((state == S_DONE) && bus.Out_ready));
  // One guard bit catches the carry out of the total for saturation
  assign sum_wide    = {1'b0, acc} + {{(ACC_W-2){1'b0}}, bus.Carry_in, bus.Sum_in};

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.Start) state_nxt = S_ACCUM;
      S_ACCUM: if (accept && (count == LAST_CNT)) state_nxt = S_DONE;
      S_DONE:  if (bus.Out_ready) state_nxt = bus.Start ? S_ACCUM : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.In_ready  = (state == S_ACCUM);
    bus.Out_valid = (state == S_DONE);
    bus.Busy      = (state == S_ACCUM) || (state == S_DONE);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      acc      <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (frame_start) begin
      acc      <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (accept) begin
      count <= count + CNT_W'(1);
      if (sum_wide[ACC_W]) begin
        acc      <= '1;
        overflow <= 1'b1;
      end else begin
        acc <= sum_wide[ACC_W-1:0];
      end
    end
  end

  assign bus.Acc_sum  = acc;
  assign bus.Overflow = overflow;

endmodule
